stage2_decode: RTL and testbench
================================

// Module: stage2_decode
// PURPOSE
//  ID stage. Consumes the IF stage output {if_ir, if_npc}, decodes RV32I, reads the 32x32 register file and registers the ID/EX bundle for EX.
//  Detects load-use hazards, drives hazard back to IF (IF holds pc/npc while it is high) and inserts a bubble.
//  Accepts the WB write port and flushes on branch_cond from EX/MEM.
// PARAMETERS
//  XLEN      32  datapath / register width
//  NREGS     32  register count (x0 hardwired 0)
//  STALL_W   16  width of hazard_count
// PORTS
//  clk             in   1      clock, all state on rising edge
//  reset           in   1      asynchronous, active-low reset
//  if_ir           in   32     instruction from IF (if_id[0])
//  if_npc          in   32     npc from IF (if_id[1])
//  branch_cond     in   1      EX/MEM.cond: flush the instruction in ID
//  wb_we           in   1      register write enable from WB
//  wb_rd           in   5      WB destination
//  wb_data         in   32     WB data
//  hazard          out  1      load-use stall request to IF (combinational)
//  hazard_count    out  STALL_W  saturating count of stall cycles
//  id_ex_valid     out  1      bundle holds a real instruction
//  id_ex_npc       out  32     registered if_npc
//  id_ex_a         out  32     rs1 value
//  id_ex_b         out  32     rs2 value
//  id_ex_imm       out  32     sign-extended immediate
//  id_ex_rd        out  5      destination (0 when no writeback)
//  id_ex_opcode    out  7      ir[6:0]
//  id_ex_funct3    out  3      ir[14:12]
//  id_ex_funct7b5  out  1      ir[30]
//  id_ex_ctrl      out  5      {reg_write, mem_read, mem_write, branch, jump}
//  id_ex_illegal   out  1      unrecognised opcode
// BEHAVIOUR
//  Reset (reset==0, async): every id_ex_* output = 0, hazard_count = 0, all registers = 0.
//   hazard = 0 (no valid load in ID/EX). Release is synchronous to clk.
//  Latency: one cycle. if_ir sampled at edge N appears on id_ex_* after edge N.
//  Decode (ir[6:0]): 0110011 R, 0010011 I-alu, 0000011 load, 0100011 store,
//   1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc.
//   Immediate formats are I/S/B/U/J per RV32I, sign-extended from ir[31]. B and J carry bit0=0.
//   R type: imm = 0. Store and branch: rd output forced to 0 and reg_write = 0.
//  Illegal opcode: valid = 1, illegal = 1, ctrl = 0, rd = 0.
//   if_ir == 32'h0 is a bubble: valid = 0, ctrl = 0, illegal = 0.
//  Regfile: x0 reads 0 and ignores writes. A write occurs on the edge with wb_we = 1 and wb_rd != 0.
//   Same-cycle read of wb_rd (!= 0) with wb_we = 1 returns wb_data (write-through bypass).
//  Hazard: hazard = id_ex_valid & ctrl.mem_read & (id_ex_rd != 0) & !branch_cond &
//   (id_ex_rd == rs1 | (id_ex_rd == rs2 & opcode uses rs2)).
//   rs2 is used by R, store and branch. rs1 is used by all except lui, auipc and jal.
//   While hazard = 1, the next edge loads a bubble (valid = 0, ctrl = 0, rd = 0) and IF holds the same if_ir.
//   A hazard lasts exactly one cycle because the bubble clears the match.
//   hazard_count increments per hazard cycle and saturates at all-ones.
//  Flush: branch_cond = 1 at an edge loads a bubble regardless of if_ir or hazard. Branch has priority over hazard.
//  Simultaneous WB write + hazard: the regfile write still occurs. The bubble carries no operands.
//  Reset mid-stream: in-flight instruction discarded, regfile contents lost.
// TESTING
//  1. Reset low, then high. Then 32'h0 on if_ir -> all id_ex_* = 0, hazard = 0.
//  2. wb x5 = 0x1234 (wb_we = 1), then if_ir = add x6,x5,x0 -> id_ex_a = 0x1234, id_ex_b = 0, rd = 6, reg_write = 1.
//     Same-cycle variant: wb x5 written in the decode cycle -> bypass gives 0x1234.
//  3. lw x7,0(x1) then add x8,x7,x2 -> hazard = 1 for exactly 1 cycle, one bubble, add decoded next cycle; hazard_count = 1.
//  4. lw x7 then branch_cond = 1 with a dependent add in ID -> hazard = 0, bubble loaded, hazard_count unchanged.
//  5. beq x1,x2,-8 (0xFE208CE3) -> imm = 0xFFFFFFF8, branch = 1, rd = 0.
//     Opcode 0x7F -> illegal = 1, ctrl = 0.
//  6. Write x0 = 0xFFFF via WB, then read x0 -> 0.
//     Assert reset mid-stream -> outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/stage2_decode.sv
// stage2_decode: ID stage of a 5-stage RV32I pipeline.
// Decodes the instruction from IF, reads the 32x32 register file (with WB write-through
// bypass), detects load-use hazards and registers the ID/EX bundle one cycle later.
//
// Ports
//   clk_i              clock, all state on rising edge
//   rst_ni             asynchronous active-low reset
//   if_ir_i/if_npc_i   instruction and next-pc from IF
//   branch_cond_i      EX/MEM taken branch: flush the instruction in ID
//   wb_we_i/wb_rd_i/wb_data_i   register write port from WB
//   hazard_o           load-use stall request to IF (combinational)
//   hazard_count_o     saturating count of stall cycles
//   id_ex_*_o          registered ID/EX bundle; ctrl = {reg_write, mem_read, mem_write,
//                      branch, jump}
module stage2_decode #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [31:0]        if_ir_i,
    input  logic [XLEN-1:0]    if_npc_i,
    input  logic               branch_cond_i,
    input  logic               wb_we_i,
    input  logic [4:0]         wb_rd_i,
    input  logic [XLEN-1:0]    wb_data_i,
    output logic               hazard_o,
    output logic [STALL_W-1:0] hazard_count_o,
    output logic               id_ex_valid_o,
    output logic [XLEN-1:0]    id_ex_npc_o,
    output logic [XLEN-1:0]    id_ex_a_o,
    output logic [XLEN-1:0]    id_ex_b_o,
    output logic [XLEN-1:0]    id_ex_imm_o,
    output logic [4:0]         id_ex_rd_o,
    output logic [6:0]         id_ex_opcode_o,
    output logic [2:0]         id_ex_funct3_o,
    output logic               id_ex_funct7b5_o,
    output logic [4:0]         id_ex_ctrl_o,
    output logic               id_ex_illegal_o
);

    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam int unsigned CtrlMemRead = 3;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2, rd_f;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = if_ir_i[6:0];
    assign rd_f   = if_ir_i[11:7];
    assign rs1    = if_ir_i[19:15];
    assign rs2    = if_ir_i[24:20];

    assign imm_i = {{(XLEN-12){if_ir_i[31]}}, if_ir_i[31:20]};
    assign imm_s = {{(XLEN-12){if_ir_i[31]}}, if_ir_i[31:25], if_ir_i[11:7]};
    assign imm_b = {{(XLEN-12){if_ir_i[31]}}, if_ir_i[7], if_ir_i[30:25], if_ir_i[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){if_ir_i[31]}}, if_ir_i[31:12], 12'b0};
    assign imm_j = {{(XLEN-20){if_ir_i[31]}}, if_ir_i[19:12], if_ir_i[20], if_ir_i[30:21],
                    1'b0};

    // Decode
    logic [4:0]      dec_ctrl;
    logic [4:0]      dec_rd;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            uses_rs1, uses_rs2;

    always_comb begin
        dec_ctrl    = 5'b00000;
        dec_rd      = rd_f;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b0;
        case (opcode)
            OpReg:    begin dec_ctrl = 5'b10000; uses_rs2 = 1'b1; end
            OpImm:    begin dec_ctrl = 5'b10000; dec_imm = imm_i; end
            OpLoad:   begin dec_ctrl = 5'b11000; dec_imm = imm_i; end
            OpStore:  begin dec_ctrl = 5'b00100; dec_imm = imm_s; dec_rd = '0; uses_rs2 = 1'b1; end
            OpBranch: begin dec_ctrl = 5'b00010; dec_imm = imm_b; dec_rd = '0; uses_rs2 = 1'b1; end
            OpJal:    begin dec_ctrl = 5'b10001; dec_imm = imm_j; uses_rs1 = 1'b0; end
            OpJalr:   begin dec_ctrl = 5'b10001; dec_imm = imm_i; end
            OpLui:    begin dec_ctrl = 5'b10000; dec_imm = imm_u; uses_rs1 = 1'b0; end
            OpAuipc:  begin dec_ctrl = 5'b10000; dec_imm = imm_u; uses_rs1 = 1'b0; end
            default:  begin dec_illegal = 1'b1; dec_rd = '0; end
        endcase
    end

    // Register file with write-through bypass from WB
    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rs1_val, rs2_val;

    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (rs1 != 5'd0) rs1_val = (wb_we_i && wb_rd_i == rs1) ? wb_data_i : rf_q[rs1];
        if (rs2 != 5'd0) rs2_val = (wb_we_i && wb_rd_i == rs2) ? wb_data_i : rf_q[rs2];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_we_i && wb_rd_i != 5'd0) begin
            rf_q[wb_rd_i] <= wb_data_i;
        end
    end

    // ID/EX bundle state
    logic               id_ex_valid_q, id_ex_valid_d;
    logic [XLEN-1:0]    id_ex_npc_q, id_ex_npc_d;
    logic [XLEN-1:0]    id_ex_a_q, id_ex_a_d;
    logic [XLEN-1:0]    id_ex_b_q, id_ex_b_d;
    logic [XLEN-1:0]    id_ex_imm_q, id_ex_imm_d;
    logic [4:0]         id_ex_rd_q, id_ex_rd_d;
    logic [6:0]         id_ex_opcode_q, id_ex_opcode_d;
    logic [2:0]         id_ex_funct3_q, id_ex_funct3_d;
    logic               id_ex_funct7b5_q, id_ex_funct7b5_d;
    logic [4:0]         id_ex_ctrl_q, id_ex_ctrl_d;
    logic               id_ex_illegal_q, id_ex_illegal_d;
    logic [STALL_W-1:0] hazard_count_q, hazard_count_d;
    logic               bubble;

    // A load in EX whose rd feeds this instruction; a flush overrides the stall.
    assign hazard_o = id_ex_valid_q & id_ex_ctrl_q[CtrlMemRead] & (id_ex_rd_q != 5'd0) &
                      ~branch_cond_i &
                      ((uses_rs1 & (id_ex_rd_q == rs1)) | (uses_rs2 & (id_ex_rd_q == rs2)));

    assign bubble = branch_cond_i | hazard_o | (if_ir_i == 32'h0);

    always_comb begin
        id_ex_valid_d    = 1'b0;
        id_ex_npc_d      = '0;
        id_ex_a_d        = '0;
        id_ex_b_d        = '0;
        id_ex_imm_d      = '0;
        id_ex_rd_d       = '0;
        id_ex_opcode_d   = '0;
        id_ex_funct3_d   = '0;
        id_ex_funct7b5_d = 1'b0;
        id_ex_ctrl_d     = '0;
        id_ex_illegal_d  = 1'b0;
        if (!bubble) begin
            id_ex_valid_d    = 1'b1;
            id_ex_npc_d      = if_npc_i;
            id_ex_a_d        = rs1_val;
            id_ex_b_d        = rs2_val;
            id_ex_imm_d      = dec_imm;
            id_ex_rd_d       = dec_rd;
            id_ex_opcode_d   = opcode;
            id_ex_funct3_d   = if_ir_i[14:12];
            id_ex_funct7b5_d = if_ir_i[30];
            id_ex_ctrl_d     = dec_ctrl;
            id_ex_illegal_d  = dec_illegal;
        end
        hazard_count_d = hazard_count_q;
        if (hazard_o && hazard_count_q != '1) hazard_count_d = hazard_count_q + STALL_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_ex_valid_q    <= 1'b0;
            id_ex_npc_q      <= '0;
            id_ex_a_q        <= '0;
            id_ex_b_q        <= '0;
            id_ex_imm_q      <= '0;
            id_ex_rd_q       <= '0;
            id_ex_opcode_q   <= '0;
            id_ex_funct3_q   <= '0;
            id_ex_funct7b5_q <= 1'b0;
            id_ex_ctrl_q     <= '0;
            id_ex_illegal_q  <= 1'b0;
            hazard_count_q   <= '0;
        end else begin
            id_ex_valid_q    <= id_ex_valid_d;
            id_ex_npc_q      <= id_ex_npc_d;
            id_ex_a_q        <= id_ex_a_d;
            id_ex_b_q        <= id_ex_b_d;
            id_ex_imm_q      <= id_ex_imm_d;
            id_ex_rd_q       <= id_ex_rd_d;
            id_ex_opcode_q   <= id_ex_opcode_d;
            id_ex_funct3_q   <= id_ex_funct3_d;
            id_ex_funct7b5_q <= id_ex_funct7b5_d;
            id_ex_ctrl_q     <= id_ex_ctrl_d;
            id_ex_illegal_q  <= id_ex_illegal_d;
            hazard_count_q   <= hazard_count_d;
        end
    end

    assign hazard_count_o   = hazard_count_q;
    assign id_ex_valid_o    = id_ex_valid_q;
    assign id_ex_npc_o      = id_ex_npc_q;
    assign id_ex_a_o        = id_ex_a_q;
    assign id_ex_b_o        = id_ex_b_q;
    assign id_ex_imm_o      = id_ex_imm_q;
    assign id_ex_rd_o       = id_ex_rd_q;
    assign id_ex_opcode_o   = id_ex_opcode_q;
    assign id_ex_funct3_o   = id_ex_funct3_q;
    assign id_ex_funct7b5_o = id_ex_funct7b5_q;
    assign id_ex_ctrl_o     = id_ex_ctrl_q;
    assign id_ex_illegal_o  = id_ex_illegal_q;

endmodule

// File: tb/tb_stage2_decode.sv
// Bench for stage2_decode: behavioural model of the ID stage compared every cycle, plus
// directed vectors with hand-computed expectations.
module tb_stage2_decode;

    localparam int SW = 3;  // small so the saturating stall counter can be reached

    typedef struct packed {
        logic        valid;
        logic [31:0] npc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b5;
        logic [4:0]  ctrl;
        logic        illegal;
    } bundle_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [31:0]   if_ir = '0, if_npc = '0, wb_data = '0;
    logic          branch_cond = 1'b0, wb_we = 1'b0;
    logic [4:0]    wb_rd = '0;

    logic          hazard;
    logic [SW-1:0] hazard_count;
    logic          id_ex_valid, id_ex_funct7b5, id_ex_illegal;
    logic [31:0]   id_ex_npc, id_ex_a, id_ex_b, id_ex_imm;
    logic [4:0]    id_ex_rd, id_ex_ctrl;
    logic [6:0]    id_ex_opcode;
    logic [2:0]    id_ex_funct3;

    int checks = 0;
    int passes = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    stage2_decode #(.XLEN(32), .NREGS(32), .STALL_W(SW)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .if_ir_i          (if_ir),
        .if_npc_i         (if_npc),
        .branch_cond_i    (branch_cond),
        .wb_we_i          (wb_we),
        .wb_rd_i          (wb_rd),
        .wb_data_i        (wb_data),
        .hazard_o         (hazard),
        .hazard_count_o   (hazard_count),
        .id_ex_valid_o    (id_ex_valid),
        .id_ex_npc_o      (id_ex_npc),
        .id_ex_a_o        (id_ex_a),
        .id_ex_b_o        (id_ex_b),
        .id_ex_imm_o      (id_ex_imm),
        .id_ex_rd_o       (id_ex_rd),
        .id_ex_opcode_o   (id_ex_opcode),
        .id_ex_funct3_o   (id_ex_funct3),
        .id_ex_funct7b5_o (id_ex_funct7b5),
        .id_ex_ctrl_o     (id_ex_ctrl),
        .id_ex_illegal_o  (id_ex_illegal)
    );

    bundle_t dut_b;
    assign dut_b = {id_ex_valid, id_ex_npc, id_ex_a, id_ex_b, id_ex_imm, id_ex_rd,
                    id_ex_opcode, id_ex_funct3, id_ex_funct7b5, id_ex_ctrl, id_ex_illegal};

    // ---------------- behavioural model ----------------
    bundle_t       m_b;
    logic [SW-1:0] m_cnt;
    logic [31:0]   m_rf [32];

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (v[bits-1]) return v | (32'hFFFF_FFFF << bits);
        return v;
    endfunction

    function automatic logic [31:0] reg_read(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (wb_we && wb_rd == idx) return wb_data;
        return m_rf[idx];
    endfunction

    function automatic bundle_t model_decode(input logic [31:0] ir, input logic [31:0] npc);
        bundle_t r;
        r         = '0;
        r.valid   = 1'b1;
        r.npc     = npc;
        r.a       = reg_read(5'((ir >> 15) & 32'h1F));
        r.b       = reg_read(5'((ir >> 20) & 32'h1F));
        r.opcode  = 7'(ir & 32'h7F);
        r.funct3  = 3'((ir >> 12) & 32'h7);
        r.f7b5    = ir[30];
        r.rd      = 5'((ir >> 7) & 32'h1F);
        case (r.opcode)
            7'h33: r.ctrl = 5'b10000;
            7'h13: begin r.ctrl = 5'b10000; r.imm = sext(ir >> 20, 12); end
            7'h03: begin r.ctrl = 5'b11000; r.imm = sext(ir >> 20, 12); end
            7'h67: begin r.ctrl = 5'b10001; r.imm = sext(ir >> 20, 12); end
            7'h23: begin
                r.ctrl = 5'b00100; r.rd = 0;
                r.imm  = sext(((ir >> 25) << 5) | ((ir >> 7) & 32'h1F), 12);
            end
            7'h63: begin
                r.ctrl = 5'b00010; r.rd = 0;
                r.imm  = sext((((ir >> 31) & 1) << 12) | (((ir >> 7) & 1) << 11) |
                              (((ir >> 25) & 32'h3F) << 5) | (((ir >> 8) & 32'hF) << 1), 13);
            end
            7'h6F: begin
                r.ctrl = 5'b10001;
                r.imm  = sext((((ir >> 31) & 1) << 20) | (((ir >> 12) & 32'hFF) << 12) |
                              (((ir >> 20) & 1) << 11) | (((ir >> 21) & 32'h3FF) << 1), 21);
            end
            7'h37, 7'h17: begin r.ctrl = 5'b10000; r.imm = ir & 32'hFFFF_F000; end
            default: begin r.illegal = 1'b1; r.rd = 0; end
        endcase
        return r;
    endfunction

    function automatic logic model_hazard();
        logic [6:0] op;
        logic       use1, use2;
        op   = 7'(if_ir & 32'h7F);
        use2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
        use1 = !((op == 7'h37) || (op == 7'h17) || (op == 7'h6F));
        return m_b.valid && m_b.ctrl[3] && (m_b.rd != 0) && !branch_cond &&
               ((use1 && m_b.rd == 5'((if_ir >> 15) & 32'h1F)) ||
                (use2 && m_b.rd == 5'((if_ir >> 20) & 32'h1F)));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_b   <= '0;
            m_cnt <= '0;
            for (int i = 0; i < 32; i++) m_rf[i] <= '0;
        end else begin
            if (model_hazard() && int'(m_cnt) < (1 << SW) - 1) m_cnt <= m_cnt + 1'b1;
            if (branch_cond || model_hazard() || if_ir == 32'h0) m_b <= '0;
            else m_b <= model_decode(if_ir, if_npc);
            if (wb_we && wb_rd != 0) m_rf[wb_rd] <= wb_data;
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("model_bundle", 160'(dut_b), 160'(m_b));
            chk("model_hazard", 160'(hazard), 160'(model_hazard()));
            chk("model_hcount", 160'(hazard_count), 160'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [31:0] ir, input logic [31:0] npc, input logic bc,
                         input logic we, input logic [4:0] wrd, input logic [31:0] wd);
        @(posedge clk);
        #1;
        if_ir       = ir;
        if_npc      = npc;
        branch_cond = bc;
        wb_we       = we;
        wb_rd       = wrd;
        wb_data     = wd;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    localparam logic [31:0] LW_X7   = 32'h0000A383;  // lw   x7,0(x1)
    localparam logic [31:0] ADD_DEP = 32'h00238433;  // add  x8,x7,x2
    localparam logic [31:0] ADD_X5  = 32'h00028333;  // add  x6,x5,x0
    localparam logic [31:0] ADD_X9  = 32'h00048333;  // add  x6,x9,x0
    localparam logic [31:0] SW_X7   = 32'h0071A023;  // sw   x7,0(x3)
    localparam logic [31:0] LUI_X9  = 32'h000384B7;  // lui  x9 (rs1 field = 7)
    localparam logic [31:0] ADDI_X9 = 32'h00708493;  // addi x9,x1,7 (rs2 field = 7)

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Bubble after reset
        nop();
        @(negedge clk);
        chk("bubble_bundle", 160'(dut_b), 160'(0));
        chk("bubble_hazard", 160'(hazard), 160'(0));

        // Regfile write then read; same-cycle bypass
        drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h1234);
        drive(ADD_X5, 32'h104, 1'b0, 1'b0, 5'd0, 32'h0);
        nop();
        @(negedge clk);
        chk("rf_a", 160'(id_ex_a), 160'(32'h1234));
        chk("rf_b", 160'(id_ex_b), 160'(32'h0));
        chk("rf_rd", 160'(id_ex_rd), 160'(5'd6));
        chk("rf_ctrl", 160'(id_ex_ctrl), 160'(5'b10000));
        drive(ADD_X9, 32'h108, 1'b0, 1'b1, 5'd9, 32'h5A5A);
        nop();
        @(negedge clk);
        chk("bypass_a", 160'(id_ex_a), 160'(32'h5A5A));

        drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'h100);
        drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'h22);
        drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd7, 32'h77);

        // Load-use stall: one hazard cycle, one bubble, then the add
        drive(LW_X7, 32'h200, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(ADD_DEP, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("lu_hazard", 160'(hazard), 160'(1));
        drive(ADD_DEP, 32'h204, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("lu_hazard_gone", 160'(hazard), 160'(0));
        chk("lu_bubble", 160'(id_ex_valid), 160'(0));
        nop();
        @(negedge clk);
        chk("lu_add_valid", 160'(id_ex_valid), 160'(1));
        chk("lu_add_rd", 160'(id_ex_rd), 160'(5'd8));
        chk("lu_add_a", 160'(id_ex_a), 160'(32'h77));
        chk("lu_count", 160'(hazard_count), 160'(1));

        // Flush wins over hazard
        drive(LW_X7, 32'h210, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(ADD_DEP, 32'h214, 1'b1, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("flush_hazard", 160'(hazard), 160'(0));
        nop();
        @(negedge clk);
        chk("flush_bubble", 160'(id_ex_valid), 160'(0));
        chk("flush_count", 160'(hazard_count), 160'(1));

        // rs2 use by store stalls; unused rs1/rs2 fields do not
        drive(LW_X7, 32'h220, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(SW_X7, 32'h224, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("sw_hazard", 160'(hazard), 160'(1));
        drive(SW_X7, 32'h224, 1'b0, 1'b0, 5'd0, 32'h0);
        nop();
        drive(LW_X7, 32'h230, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(LUI_X9, 32'h234, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("lui_no_hazard", 160'(hazard), 160'(0));
        nop();
        drive(LW_X7, 32'h240, 1'b0, 1'b0, 5'd0, 32'h0);
        drive(ADDI_X9, 32'h244, 1'b0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        chk("addi_no_hazard", 160'(hazard), 160'(0));
        nop();

        // Drive the stall counter past all-ones (2 so far + 6 more)
        for (int i = 0; i < 6; i++) begin
            drive(LW_X7, 32'h300, 1'b0, 1'b0, 5'd0, 32'h0);
            drive(ADD_DEP, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0);
            drive(ADD_DEP, 32'h304, 1'b0, 1'b0, 5'd0, 32'h0);
        end
        nop();
        @(negedge clk);
        chk("count_saturated", 160'(hazard_count), 160'(7));

        // Branch / illegal / jal decode
        drive(32'hFE208CE3, 32'h400, 1'b0, 1'b0, 5'd0, 32'h0);
        nop();
        @(negedge clk);
        chk("beq_imm", 160'(id_ex_imm), 160'(32'hFFFF_FFF8));
        chk("beq_ctrl", 160'(id_ex_ctrl), 160'(5'b00010));
        chk("beq_rd", 160'(id_ex_rd), 160'(5'd0));
        drive(32'h0000007F, 32'h404, 1'b0, 1'b0, 5'd0, 32'h0);
        nop();
        @(negedge clk);
        chk("ill_flag", 160'(id_ex_illegal), 160'(1));
        chk("ill_valid", 160'(id_ex_valid), 160'(1));
        chk("ill_ctrl", 160'(id_ex_ctrl), 160'(0));
        drive(32'hFFDFF0EF, 32'h408, 1'b0, 1'b0, 5'd0, 32'h0);  // jal x1,-4
        nop();
        @(negedge clk);
        chk("jal_imm", 160'(id_ex_imm), 160'(32'hFFFF_FFFC));
        chk("jal_ctrl", 160'(id_ex_ctrl), 160'(5'b10001));
        chk("jal_npc", 160'(id_ex_npc), 160'(32'h408));

        // x0 ignores writes
        drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 32'hFFFF);
        drive(32'h00000333, 32'h500, 1'b0, 1'b0, 5'd0, 32'h0);  // add x6,x0,x0
        nop();
        @(negedge clk);
        chk("x0_read", 160'(id_ex_a), 160'(0));

        // Asynchronous reset mid-stream
        drive(32'h00528513, 32'h600, 1'b0, 1'b0, 5'd0, 32'h0);  // addi x10,x5,5
        nop();
        @(negedge clk);
        chk("pre_rst_valid", 160'(id_ex_valid), 160'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_bundle", 160'(dut_b), 160'(0));
        chk("async_rst_count", 160'(hazard_count), 160'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(ADD_X5, 32'h700, 1'b0, 1'b0, 5'd0, 32'h0);
        nop();
        @(negedge clk);
        chk("rf_cleared", 160'(id_ex_a), 160'(0));

        @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
